// File: rtl/cpu5_ifu_pkg.sv
// Shared types and constants for the cpu5 instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu5_ifu_pkg;

  localparam int CPU5_OPCODE_SIZE = 7;
  localparam int CPU5_INST_SIZE   = 32;
  localparam int CPU5_ADDR_SIZE   = 32;

  localparam logic [CPU5_ADDR_SIZE-1:0] CPU5_PC_RESET = 32'h0000_0000;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    CPU5_IFU_ST_START = 2'd0,
    CPU5_IFU_ST_RUN   = 2'd1,
    CPU5_IFU_ST_FLUSH = 2'd2
  } ifu_state_e;

  // One buffered fetch: the instruction and the PC it was fetched from
  typedef struct packed {
    logic [CPU5_ADDR_SIZE-1:0] pc;
    logic [CPU5_INST_SIZE-1:0] inst;
  } ifu_entry_t;

  // Redirect targets are forced onto a word boundary
  function automatic logic [CPU5_ADDR_SIZE-1:0] align_pc(input logic [CPU5_ADDR_SIZE-1:0] a);
    return a & ~CPU5_ADDR_SIZE'(3);
  endfunction

endpackage

// File: rtl/cpu5_ifu_fifo.sv
// Small synchronous FIFO of {pc, inst} entries between imem responses and decode.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is dropped when full unless a pop happens the same cycle; flush empties it.
module cpu5_ifu_fifo
  import cpu5_ifu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  ifu_entry_t    push_dat,
  input  logic          pop,
  input  logic          flush,
  output ifu_entry_t    head_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ifu_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (r_count == '0);
  assign full     = (r_count == CW'(DEPTH));
  assign count    = r_count;
  assign head_dat = r_mem[r_rd_ptr];
  assign w_pop    = pop && !empty;
  assign w_push   = push && (!full || w_pop);

  // Pointer and occupancy tracking; flush discards everything after any same-cycle pop
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Entry storage; cleared on reset so the head reads zero out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= push_dat;
    end
  end

endmodule

// File: rtl/cpu5_ifu.sv
// cpu5 instruction fetch: holds the PC, issues in-order imem fetches, buffers results for decode.
// Latency: an instruction reaches dec_valid the cycle after its imem response.
// Backpressure: requests stop once in-flight plus buffered fetches reach BUF_DEPTH; decode pops via valid/ready.
module cpu5_ifu
  import cpu5_ifu_pkg::*;
#(
  parameter logic [CPU5_ADDR_SIZE-1:0] RESET_PC  = CPU5_PC_RESET,
  parameter int                        BUF_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        imem_req_valid,
  input  logic                        imem_req_ready,
  output logic [CPU5_ADDR_SIZE-1:0]   imem_req_addr,
  input  logic                        imem_resp_valid,
  input  logic [CPU5_INST_SIZE-1:0]   imem_resp_inst,
  input  logic                        redirect_valid,
  input  logic [CPU5_ADDR_SIZE-1:0]   redirect_pc,
  output logic                        dec_valid,
  input  logic                        dec_ready,
  output logic [CPU5_INST_SIZE-1:0]   dec_inst,
  output logic [CPU5_ADDR_SIZE-1:0]   dec_pc,
  output logic [CPU5_OPCODE_SIZE-1:0] dec_op
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  ifu_state_e                r_state;
  logic [CPU5_ADDR_SIZE-1:0] r_pc;
  logic [CW-1:0]             r_inflight;
  logic [CW-1:0]             r_drop;

  logic          w_redir;
  logic          w_credit;
  logic          w_acc;
  logic          w_resp_run;
  logic          w_resp_flush;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_drop_run;
  logic [CW-1:0] w_drop_flush;
  ifu_entry_t    w_push_dat;
  ifu_entry_t    w_head_dat;

  // Redirects are ignored during START; nothing has been fetched yet
  assign w_redir  = redirect_valid && (r_state != CPU5_IFU_ST_START);
  assign w_credit = !w_full && ((r_inflight + w_count) < CW'(BUF_DEPTH));

  assign imem_req_valid = (r_state == CPU5_IFU_ST_RUN) && w_credit && !redirect_valid;
  assign imem_req_addr  = r_pc;
  assign w_acc          = imem_req_valid && imem_req_ready;

  assign w_resp_run   = imem_resp_valid && (r_inflight != '0);
  assign w_resp_flush = imem_resp_valid && (r_drop != '0);

  // Outstanding fetches are contiguous and end just below r_pc, so the oldest one is r_pc - 4*inflight
  assign w_push_dat.pc   = r_pc - (32'(r_inflight) << 2);
  assign w_push_dat.inst = imem_resp_inst;
  assign w_push          = (r_state == CPU5_IFU_ST_RUN) && imem_resp_valid && !w_redir;

  // A response landing with the redirect is already accounted for, so it leaves the drop count
  assign w_drop_run   = r_inflight + CW'(w_acc) - CW'(w_resp_run);
  assign w_drop_flush = r_drop - CW'(w_resp_flush);

  assign dec_valid = !w_empty;
  assign w_pop     = dec_valid && dec_ready;
  assign dec_inst  = w_head_dat.inst;
  assign dec_pc    = w_head_dat.pc;
  assign dec_op    = w_head_dat.inst[CPU5_OPCODE_SIZE-1:0];

  cpu5_ifu_fifo #(
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (w_push),
    .push_dat (w_push_dat),
    .pop      (w_pop),
    .flush    (w_redir),
    .head_dat (w_head_dat),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count)
  );

  // Fetch sequencer: PC, in-flight credit and post-redirect drop accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= CPU5_IFU_ST_START;
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      case (r_state)
        CPU5_IFU_ST_START: begin
          r_state <= CPU5_IFU_ST_RUN;
        end
        CPU5_IFU_ST_RUN: begin
          if (w_redir) begin
            r_pc       <= align_pc(redirect_pc);
            r_inflight <= '0;
            r_drop     <= w_drop_run;
            r_state    <= (w_drop_run != '0) ? CPU5_IFU_ST_FLUSH : CPU5_IFU_ST_RUN;
          end else begin
            if (w_acc) r_pc <= r_pc + 32'd4;
            r_inflight <= r_inflight + CW'(w_acc) - CW'(w_resp_run);
          end
        end
        CPU5_IFU_ST_FLUSH: begin
          if (w_redir) r_pc <= align_pc(redirect_pc);
          r_drop <= w_drop_flush;
          if (w_drop_flush == '0) r_state <= CPU5_IFU_ST_RUN;
        end
        default: begin
          r_state <= CPU5_IFU_ST_START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu5_ifu.sv
// Self-checking bench for cpu5_ifu: in-order imem model, decode scoreboard, redirect table and corner sequences.
module tb_cpu5_ifu;
  import cpu5_ifu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [6:0]  dec_op;

  cpu5_ifu #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_inst  (imem_resp_inst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_inst        (dec_inst),
    .dec_pc          (dec_pc),
    .dec_op          (dec_op)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int tag; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } dexp_t;
  typedef struct { logic [31:0] rpc; logic [31:0] first; logic [31:0] second; } rd_vec_t;

  mreq_t       mq[$];
  dexp_t       sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          lat_cfg = 1;
  int          acc_cnt = 0;
  logic [31:0] exp_req_addr = RST_PC;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_2083;
    return {a[26:2], 7'b0110011};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // imem model: in-order responses, each no earlier than lat_cfg cycles after acceptance
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_inst  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_inst  = inst_of(mq[0].addr);
      end else begin
        imem_resp_valid = 1'b0;
      end
    end
  end

  // Monitor: decode scoreboard, response bookkeeping, redirect epochs, request address order
  initial begin
    dexp_t d;
    mreq_t m;
    forever begin
      @(negedge clk);
      if (reset) begin
        mq.delete();
        sb.delete();
        epoch++;
        exp_req_addr = RST_PC;
      end else begin
        if (dec_valid && dec_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL dec_unexpected: got pc %h, required no delivery", dec_pc);
          end else begin
            d = sb.pop_front();
            check("dec_pc", dec_pc, d.pc);
            check("dec_inst", dec_inst, d.inst);
          end
        end
        if (imem_resp_valid && mq.size() > 0) begin
          m = mq.pop_front();
          if (m.tag == epoch && !redirect_valid) sb.push_back('{m.addr, inst_of(m.addr)});
        end
        if (redirect_valid) begin
          epoch++;
          sb.delete();
          exp_req_addr = {redirect_pc[31:2], 2'b00};
        end
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr", imem_req_addr, exp_req_addr);
          exp_req_addr = exp_req_addr + 32'd4;
          acc_cnt++;
          mq.push_back('{imem_req_addr, epoch, cyc + lat_cfg});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    redirect_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_req(output logic [31:0] a);
    bit got;
    got = 1'b0;
    a = 32'h0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        got = 1'b1;
        a = imem_req_addr;
      end
    end
    check("wait_req_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_dec(output logic [31:0] pc);
    bit got;
    got = 1'b0;
    pc = 32'h0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (dec_valid) begin
        got = 1'b1;
        pc = dec_pc;
      end
    end
    check("wait_dec_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $finish;
  end

  initial begin
    rd_vec_t     tbl[4];
    logic [31:0] a;
    int          a0;

    tbl[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
    tbl[1] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
    tbl[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
    tbl[3] = '{32'h0000_2005, 32'h0000_2004, 32'h0000_2008};

    reset          = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;

    // Reset values, START cycle, then first fetch and LW opcode
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_dec_pc", dec_pc, 32'h0);
    check("rst_dec_inst", dec_inst, 32'h0);
    @(negedge clk);
    check("run_req_valid", 32'(imem_req_valid), 32'd1);
    check("run_req_addr", imem_req_addr, RST_PC);
    step();
    dec_ready = 1'b1;
    wait_dec(a);
    check("first_dec_pc", a, 32'h0);
    check("lw_dec_op", 32'(dec_op), 32'h0000_0003);
    repeat (8) step();

    // Random backpressure on both handshakes
    for (int i = 0; i < 60; i++) begin
      step();
      dec_ready      = 1'($urandom_range(0, 1));
      imem_req_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    dec_ready      = 1'b1;
    imem_req_ready = 1'b1;
    repeat (4) step();

    // Decode stalled: credit caps fetches at two, then drains in order
    dec_ready = 1'b0;
    do_reset();
    a0 = acc_cnt;
    repeat (12) step();
    @(negedge clk);
    check("stall_acc_count", 32'(acc_cnt - a0), 32'd2);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_dec_pc", dec_pc, 32'h0);
    step();
    dec_ready = 1'b1;
    wait_req(a);
    check("stall_next_fetch", a, 32'h8);
    repeat (6) step();

    // Redirect with two fetches in flight: both dropped
    lat_cfg = 3;
    do_reset();
    wait_req(a);
    wait_req(a);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    check("rd2_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("flush_no_req0", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    check("flush_no_req1", 32'(imem_req_valid), 32'd0);
    lat_cfg = 1;
    wait_req(a);
    check("flush_fetch", a, 32'h100);
    wait_dec(a);
    check("flush_dec_pc", a, 32'h100);
    repeat (4) step();

    // Redirect in the cycle the fetch of 0x8 would issue
    dec_ready = 1'b0;
    do_reset();
    repeat (6) @(negedge clk);
    check("full_req_valid", 32'(imem_req_valid), 32'd0);
    check("full_dec_valid", 32'(dec_valid), 32'd1);
    step();
    dec_ready = 1'b1;
    step();
    dec_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    check("rd8_req_gated", 32'(imem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    dec_ready      = 1'b1;
    wait_req(a);
    check("rd8_fetch", a, 32'h200);
    wait_dec(a);
    check("rd8_dec_pc", a, 32'h200);
    repeat (4) step();

    // Redirect coinciding with a pop of a full buffer
    dec_ready = 1'b0;
    do_reset();
    repeat (6) @(negedge clk);
    step();
    dec_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    @(negedge clk);
    check("rdpop_dec_pc", dec_pc, 32'h0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rdpop_flushed", 32'(dec_valid), 32'd0);
    check("rdpop_req_valid", 32'(imem_req_valid), 32'd1);
    check("rdpop_req_addr", imem_req_addr, 32'h100);
    wait_dec(a);
    check("rdpop_dec_first", a, 32'h100);
    repeat (4) step();

    // Redirect table: alignment and wrap-around
    dec_ready = 1'b1;
    do_reset();
    repeat (5) step();
    for (int i = 0; i < 4; i++) begin
      step();
      dec_ready      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = tbl[i].rpc;
      step();
      redirect_valid = 1'b0;
      wait_req(a);
      check("tbl_first_fetch", a, tbl[i].first);
      wait_req(a);
      check("tbl_second_fetch", a, tbl[i].second);
      step();
      dec_ready = 1'b1;
      wait_dec(a);
      check("tbl_first_dec", a, tbl[i].first);
      repeat (4) step();
    end

    // Reset while flushing
    lat_cfg = 3;
    do_reset();
    wait_req(a);
    wait_req(a);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();
    redirect_valid = 1'b0;
    reset          = 1'b1;
    step();
    reset   = 1'b0;
    lat_cfg = 1;
    @(negedge clk);
    check("frst_req_valid", 32'(imem_req_valid), 32'd0);
    check("frst_dec_valid", 32'(dec_valid), 32'd0);
    check("frst_req_addr", imem_req_addr, RST_PC);
    check("frst_dec_pc", dec_pc, 32'h0);
    check("frst_dec_inst", dec_inst, 32'h0);
    @(negedge clk);
    check("frst_run_req", 32'(imem_req_valid), 32'd1);
    check("frst_run_addr", imem_req_addr, RST_PC);
    wait_dec(a);
    check("frst_dec_first", a, RST_PC);
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
